// File: rtl/instr_stream_encoder_pkg.sv
// Shared MIPS subset definitions: instruction-class enum, primary opcodes,
// R-type function codes and the loader session states. The opcode and funct
// constants are the same values the core's main decoder matches against.
package instr_stream_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_J    = 4'd9
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_stream_encoder_word.sv
// instr_word_encoder: purely combinational (class, fields) -> 32-bit word.
//   op              instruction class (op_e encoding)
//   rs, rt, rd      register fields (rd used by R-type only)
//   imm             immediate / branch offset (I-type)
//   target          jump target (J)
//   word            encoded instruction, 0 when the class is illegal
//   legal           class is part of the supported subset
module instr_word_encoder
  import instr_stream_encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADD:  word = r_word(rs, rt, rd, FN_ADD);
      OP_SUB:  word = r_word(rs, rt, rd, FN_SUB);
      OP_AND:  word = r_word(rs, rt, rd, FN_AND);
      OP_OR:   word = r_word(rs, rt, rd, FN_OR);
      OP_SLT:  word = r_word(rs, rt, rd, FN_SLT);
      OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
      OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
      OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
      OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
      OP_J:    word = {OPC_J, target};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: program loader that encodes a stream of symbolic
// instructions and writes them sequentially into instruction memory.
//   clk, rst            clock, asynchronous active-high reset
//   start, finish       open/restart and close a load session
//   in_valid/in_ready   input beat handshake; in_op + fields describe the beat
//   imem_we/addr/wdata  one-cycle write strobe, byte address, encoded word
//   word_count          words written in the current session
//   busy, done          session open; one-cycle pulse when a session closes
//   err_illegal         sticky flag: an unsupported class was seen this session
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT  = {1'b0, {ADDR_W{1'b1}}};

  state_e      state_q, state_d;
  logic [31:0] next_addr;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        done_d;

  instr_word_encoder u_enc (
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // start blocks the beat so a restart never races a write into the old session
  assign in_ready = (state_q == ST_LOAD) && !start && (word_count < DEPTH_CNT);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (start) begin
          state_d = ST_LOAD;
        end else if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (accept && enc_legal && (word_count == LAST_CNT)) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (start) begin
          state_d = ST_LOAD;
        end else if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      word_count  <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      next_addr   <= BASE_ADDR;
    end else begin
      imem_we <= 1'b0;
      done    <= done_d;
      if (start) begin
        next_addr   <= BASE_ADDR;
        word_count  <= '0;
        err_illegal <= 1'b0;
      end else if (accept) begin
        if (enc_legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= next_addr;
          imem_wdata <= enc_word;
          next_addr  <= next_addr + 32'd4;
          word_count <= word_count + (ADDR_W+1)'(1);
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule
